// File: rtl/video_loader_pkg.sv
// Shared definitions for the video loader: FSM state type, frame geometry
// and the byte-index helper used by the packer.
package video_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    RELEASE = 2'd3
  } loader_state_t;

  localparam int unsigned FRAME_WORDS = 19200;
  localparam int unsigned FB_ADDR_W   = 15;

  // Index of the byte that completes a word: 3 for RGBA words, 2 for RGB words.
  function automatic logic [1:0] last_byte_idx(input logic pack_rgb);
    if (pack_rgb) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

endpackage

// File: rtl/video_loader_if.sv
// Byte-stream input and frame-buffer write bus of the video loader.
// master = the loader, slave = the byte source / video block side.
interface video_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic [31:0] addr_in;
  logic        data_write;
  logic        data_ack;

  modport master (
    input  in_data, in_valid, data_ack,
    output in_ready, data_in, addr_in, data_write
  );

  modport slave (
    output in_data, in_valid, data_ack,
    input  in_ready, data_in, addr_in, data_write
  );
endinterface

// File: rtl/video_loader.sv
// Packs an incoming byte stream into little-endian 32-bit pixel words and
// writes them to consecutive frame-buffer addresses with a four-phase
// data_write/data_ack handshake. Pulses frame_done after the last word.
module video_loader
  import video_pkg::*;
#(
  parameter int unsigned WORDS    = FRAME_WORDS,
  parameter int unsigned PACK_RGB = 0
) (
  input  logic           system_clock,
  input  logic           reset_n,
  input  logic           start,
  video_loader_if.master bus,
  output logic           busy,
  output logic           frame_done
);

  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(WORDS - 1);
  localparam logic [1:0]           LAST_IDX  = last_byte_idx(PACK_RGB != 0);

  loader_state_t        state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [FB_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]          word_q, word_d;
  logic                 restart_q, restart_d;   // start seen during a handshake
  logic                 in_ready_q, in_ready_d;
  logic                 data_write_q, data_write_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;

  // Next-state logic: FSM, byte packer, address counter and output levels.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    word_d       = word_q;
    restart_d    = restart_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = COLLECT;
          idx_d     = 2'd0;
          addr_d    = '0;
          word_d    = 32'd0;
          restart_d = 1'b0;
          busy_d    = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end

      COLLECT: begin
        if (start) begin
          // Re-arm: drop the partial word and go back to the first address.
          idx_d  = 2'd0;
          addr_d = '0;
          word_d = 32'd0;
        end else if (bus.in_valid && in_ready_q) begin
          word_d[{idx_q, 3'b000} +: 8] = bus.in_data;
          if (idx_q == LAST_IDX) begin
            idx_d   = 2'd0;
            state_d = WRITE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end

      WRITE: begin
        if (start) begin
          restart_d = 1'b1;
        end else begin
          restart_d = restart_q;
        end
        if (bus.data_ack) begin
          state_d = RELEASE;
        end else begin
          state_d = WRITE;
        end
      end

      RELEASE: begin
        if (!bus.data_ack) begin
          if (start || restart_q) begin
            // A restart wins over address advance and frame completion.
            state_d   = COLLECT;
            idx_d     = 2'd0;
            addr_d    = '0;
            word_d    = 32'd0;
            restart_d = 1'b0;
          end else if (addr_q == LAST_ADDR) begin
            state_d      = IDLE;
            addr_d       = '0;
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
          end else begin
            state_d = COLLECT;
            addr_d  = addr_q + 15'd1;
          end
        end else begin
          if (start) begin
            restart_d = 1'b1;
          end else begin
            restart_d = restart_q;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        idx_d     = 2'd0;
        addr_d    = '0;
        restart_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase

    in_ready_d   = (state_d == COLLECT);
    data_write_d = (state_d == WRITE);
  end

  // State and output registers; reset drops data_write at once.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      addr_q       <= '0;
      word_q       <= 32'd0;
      restart_q    <= 1'b0;
      in_ready_q   <= 1'b0;
      data_write_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      word_q       <= word_d;
      restart_q    <= restart_d;
      in_ready_q   <= in_ready_d;
      data_write_q <= data_write_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.data_in    = word_q;
  assign bus.addr_in    = {17'd0, addr_q};
  assign bus.data_write = data_write_q;
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;

endmodule

// File: doc/video_loader.md
# video_loader

Byte-stream to frame-buffer writer sitting directly upstream of the video output block. Accepts a byte stream of pixel data, for example from a download channel, and packs bytes into 32-bit little-endian pixel words. Writes each word to sequential frame-buffer word addresses using the video block's four-phase `data_write`/`data_ack` handshake. Signals completion of each full 160x120 frame.

## Interface

**Parameters**
- `WORDS`, default 19200: words per frame (160x120); must be ≥2.
- `PACK_RGB`, default 0: 0 = four bytes per word; 1 = three bytes per word, with bits [31:24] forced to 0.

**Ports**
- Clock and reset: one clock; reset is asynchronous and active-low.
- `system_clock` in 1: the only clock.
- `reset_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse; (re)arms the loader at word address 0.
- `in_data` in 8: pixel byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: byte is accepted on a cycle with `in_valid && in_ready`.
- `data_in` out 32: packed word to the video block.
- `addr_in` out 32: word address; bits [31:15] are always 0.
- `data_write` out 1: write request, level signal.
- `data_ack` in 1: acknowledge from the video block.
- `busy` out 1: armed and frame not yet complete.
- `frame_done` out 1: one-cycle pulse after the last word's handshake completes.

## Operation

**Reset values.** All outputs are 0, the state is IDLE, the byte index is 0 and the address is 0.

**States**
- IDLE
  - `in_ready` = 0.
  - `start` → COLLECT, with address 0, byte index 0 and `busy` = 1.
- COLLECT
  - `in_ready` = 1.
  - Each accepted byte is placed at `data_in[8*idx +: 8]`, and `idx` increments.
  - First byte → bits [7:0] (red). Second → [15:8] (green). Third → [23:16] (blue). Fourth, only when `PACK_RGB` = 0 → [31:24].
  - On acceptance of the last byte (idx = 3, or idx = 2 when `PACK_RGB` = 1), idx returns to 0 and the state goes to WRITE.
- WRITE
  - `data_write` = 1; `data_in` and `addr_in` are held stable.
  - `data_ack` sampled high → `data_write` = 0 on the next cycle, state RELEASE.
- RELEASE
  - `data_write` = 0.
  - `data_ack` sampled low, and address ≠ `WORDS`−1 → address +1, state COLLECT.
  - `data_ack` sampled low, and address = `WORDS`−1 → address wraps to 0, `frame_done` pulses, `busy` = 0, state IDLE.

**Boundary conditions**
- `start` in COLLECT: the partial word is discarded, idx = 0, address = 0, and the state stays COLLECT.
- `start` in WRITE or RELEASE: latched. The handshake runs to completion, with no address increment and no `frame_done`. The loader then re-enters COLLECT at address 0.
- `start` coinciding with the final RELEASE completion: `start` wins. `frame_done` is suppressed and the state is COLLECT at address 0.
- `in_valid` is ignored outside COLLECT, and no byte is lost because `in_ready` = 0 there.
- `data_ack` already high on entry to WRITE: it is treated as ack, so WRITE lasts exactly one cycle.
- Reset asserted mid-handshake: `data_write` drops immediately (asynchronously), and all state is cleared.

**Width rules**
- The address counter is 15 bits; `addr_in` = {17'd0, addr}.
- The compare against `WORDS`−1 uses a 15-bit constant.

## Timing

- **All outputs registered.** No combinational path from any input to any output.
- **Collect to write.** Last byte accepted at edge T → `data_write` = 1 from T+1.
- **Handshake latency.** With the video block's one-cycle ack latency:
  - ack high seen at T+2;
  - `data_write` low at T+3;
  - ack low seen at T+4;
  - COLLECT (`in_ready` = 1) from T+5.
- **Throughput.** The minimum word period is 4 bytes + 4 handshake cycles, i.e. 8 cycles (`PACK_RGB` = 0) or 7 cycles (`PACK_RGB` = 1).
- **Frame completion.** `frame_done` is asserted in the cycle RELEASE exits to IDLE; `busy` falls in the same cycle.

## Structure

- Shared package `video_pkg`:
  - `loader_state_t` enum (IDLE, COLLECT, WRITE, RELEASE);
  - `FRAME_WORDS` = 19200;
  - `FB_ADDR_W` = 15.
- `WORDS` defaults to `video_pkg::FRAME_WORDS`.
- Single module; no sub-module is warranted. The byte packer is a few registers inside the FSM.

## Test plan

- **Single word.** Reset, `start`, then bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles; a model ack returns with one-cycle latency → `data_in` = 0x44332211, `addr_in` = 0, `data_write` high for exactly 2 cycles, and `in_ready` high again 4 cycles after `data_write` rose.
- **RGB packing.** With `PACK_RGB` = 1, bytes 0xAA, 0xBB, 0xCC → `data_in` = 0x00CCBBAA, and the next word is written at `addr_in` = 1.
- **Full frame.** With `WORDS` = 4, stream 16 bytes with random `in_valid` gaps → four writes at addresses 0–3, then `frame_done` as a single pulse, `busy` = 0 and `in_ready` = 0; a 17th byte is not accepted.
- **Restart paths.**
  - `start` after 2 bytes of a word → the partial word is discarded, and the next 4 bytes are written at address 0.
  - `start` during WRITE → the pending write completes at its original address, then the following word is written at address 0.
- **Ack stall.** `data_ack` held low for 50 cycles → `data_write` and `data_in` remain stable throughout, and `in_ready` stays 0.
- **Reset mid-handshake.** `reset_n` asserted low while `data_write` = 1 → `data_write` goes 0 immediately; after release the state is IDLE with all outputs 0.
